// File: rtl/hazard_pkg.sv
// Shared encodings, stage record and helpers for the pipeline hazard unit.
package hazard_pkg;

  localparam int PKG_ADDR_W = 5;
  localparam int PKG_TNEW_W = 3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [PKG_TNEW_W-1:0] TUSE_NEVER = 3'd7;

  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-1:0] dst;
    logic [PKG_TNEW_W-1:0] tnew;
  } stage_t;

  function automatic logic [PKG_TNEW_W-1:0] satDec(logic [PKG_TNEW_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // $0 is hardwired, so it never produces a hazard or a forward.
  function automatic logic stageHit(stage_t s, logic [PKG_ADDR_W-1:0] a);
    return s.write && (s.dst == a) && (a != '0);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Down-counter tracking how many more cycles the HI/LO unit stays busy.
module md_busy_counter #(
  parameter int CNT_W = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= loadVal;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/forward controller for the 5-stage pipeline: tracks E/M/W producers
// and the mult/div unit, resolves D-stage stalls and D/E forward selects.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int TNEW_W      = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] d_rs_addr,
  input  logic [REG_ADDR_W-1:0] d_rt_addr,
  input  logic [TNEW_W-1:0]     d_tuse_rs,
  input  logic [TNEW_W-1:0]     d_tuse_rt,
  input  logic [TNEW_W-1:0]     d_tnew,
  input  logic                  d_reg_write,
  input  logic [REG_ADDR_W-1:0] d_dst_addr,
  input  logic                  d_md_start,
  input  logic                  d_md_is_div,
  input  logic                  d_md_access,
  output logic                  stall,
  output logic [1:0]            fwd_d_rs,
  output logic [1:0]            fwd_d_rt,
  output logic [1:0]            fwd_e_rs,
  output logic [1:0]            fwd_e_rt,
  output logic                  md_busy
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  stage_t                  stE, stM, stW;
  logic [REG_ADDR_W-1:0]   eRs, eRt;
  logic                    eMd;

  // Operand index 0 = rs, 1 = rt.
  logic [1:0][REG_ADDR_W-1:0] dSrc, eSrc;
  logic [1:0][TNEW_W-1:0]     dTuse;
  logic [1:0]                 opHaz;
  logic [1:0][1:0]            fwdD, fwdE;
  logic                       mdHaz, mdLoad;
  logic [CNT_W-1:0]           mdLoadVal;

  assign dSrc  = {d_rt_addr, d_rs_addr};
  assign dTuse = {d_tuse_rt, d_tuse_rs};
  assign eSrc  = {eRt, eRs};

  always_comb begin
    opHaz = '0;
    fwdD  = '0;
    fwdE  = '0;
    for (int i = 0; i < 2; i++) begin
      // Youngest producer wins; an older stage may hold a stale value.
      if (stageHit(stE, dSrc[i])) begin
        opHaz[i] = (dTuse[i] != TUSE_NEVER) && (stE.tnew > dTuse[i]);
        fwdD[i]  = (stE.tnew == '0) ? FWD_E : FWD_RF;
      end else if (stageHit(stM, dSrc[i])) begin
        opHaz[i] = (dTuse[i] != TUSE_NEVER) && (stM.tnew > dTuse[i]);
        fwdD[i]  = (stM.tnew == '0) ? FWD_M : FWD_RF;
      end else if (stageHit(stW, dSrc[i])) begin
        opHaz[i] = (dTuse[i] != TUSE_NEVER) && (stW.tnew > dTuse[i]);
        fwdD[i]  = (stW.tnew == '0) ? FWD_W : FWD_RF;
      end

      if (stageHit(stM, eSrc[i]))
        fwdE[i] = (stM.tnew == '0) ? FWD_M : FWD_RF;
      else if (stageHit(stW, eSrc[i]))
        fwdE[i] = (stW.tnew == '0) ? FWD_W : FWD_RF;
    end
  end

  // eMd covers the edge where an md op has just entered E; the counter is
  // already non-zero then, so this only matters for a zero-latency config.
  assign mdHaz = d_md_access && (md_busy || eMd);
  assign stall = |opHaz || mdHaz;

  assign fwd_d_rs = fwdD[0];
  assign fwd_d_rt = fwdD[1];
  assign fwd_e_rs = fwdE[0];
  assign fwd_e_rt = fwdE[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      stE <= '0;
      stM <= '0;
      stW <= '0;
      eRs <= '0;
      eRt <= '0;
      eMd <= 1'b0;
    end else begin
      stM <= '{write: stE.write, dst: stE.dst, tnew: satDec(stE.tnew)};
      stW <= '{write: stM.write, dst: stM.dst, tnew: satDec(stM.tnew)};
      if (stall) begin
        stE <= '0;
        eRs <= '0;
        eRt <= '0;
        eMd <= 1'b0;
      end else begin
        stE <= '{write: d_reg_write, dst: d_dst_addr, tnew: d_tnew};
        eRs <= d_rs_addr;
        eRt <= d_rt_addr;
        eMd <= d_md_start;
      end
    end
  end

  assign mdLoad    = !stall && d_md_start;
  assign mdLoadVal = d_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  md_busy_counter #(.CNT_W(CNT_W)) uMdCnt (
    .clk     (clk),
    .reset   (reset),
    .load    (mdLoad),
    .loadVal (mdLoadVal),
    .busy    (md_busy)
  );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Randomized + directed bench for pipeline_hazard_unit against an age-based
// model of in-flight instructions and an absolute-time HI/LO busy window.
module tb_pipeline_hazard_unit;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs_addr, d_rt_addr, d_dst_addr;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_reg_write, d_md_start, d_md_is_div, d_md_access;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  pipeline_hazard_unit #(
    .REG_ADDR_W(5), .TNEW_W(3), .MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
    .d_reg_write(d_reg_write), .d_dst_addr(d_dst_addr),
    .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_md_access(d_md_access),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // pipe[k] = instruction that entered E k cycles ago (0=E, 1=M, 2=W)
  typedef struct {bit v; bit wr; int dst; int tnew; int rs; int rt;} inst_t;
  inst_t pipe[3];
  int cyc, mdFree;
  int nChecks = 0, nErrors = 0;
  int eStall, eFdRs, eFdRt, eFeRs, eFeRt, eBusy;
  int lastStall, lastBusy;

  task automatic chk(string tag, logic [31:0] got, int exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int remT(int k);
    return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
  endfunction

  function automatic bit holds(int k, int a);
    return pipe[k].v && pipe[k].wr && pipe[k].dst == a && a != 0;
  endfunction

  function automatic void dOperand(int a, int tuse, output bit haz, output int src);
    haz = 0;
    src = 0;
    for (int k = 0; k < 3; k++)
      if (holds(k, a)) begin
        haz = (tuse != 7) && (remT(k) > tuse);
        src = (remT(k) == 0) ? k + 1 : 0;
        return;
      end
  endfunction

  function automatic int eOperand(int a);
    for (int k = 1; k < 3; k++)
      if (holds(k, a)) return (remT(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic void modelEval();
    bit hRs, hRt;
    dOperand(int'(d_rs_addr), int'(d_tuse_rs), hRs, eFdRs);
    dOperand(int'(d_rt_addr), int'(d_tuse_rt), hRt, eFdRt);
    eBusy  = (cyc < mdFree) ? 1 : 0;
    eStall = (hRs || hRt || (d_md_access && eBusy != 0)) ? 1 : 0;
    eFeRs  = pipe[0].v ? eOperand(pipe[0].rs) : 0;
    eFeRt  = pipe[0].v ? eOperand(pipe[0].rt) : 0;
  endfunction

  function automatic void modelClear();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    mdFree = 0;
    cyc    = 0;
  endfunction

  function automatic void modelAdvance();
    if (reset) begin
      modelClear();
      return;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = '{default: 0};
    if (eStall == 0) begin
      pipe[0].v    = 1;
      pipe[0].wr   = d_reg_write;
      pipe[0].dst  = int'(d_dst_addr);
      pipe[0].tnew = int'(d_tnew);
      pipe[0].rs   = int'(d_rs_addr);
      pipe[0].rt   = int'(d_rt_addr);
      if (d_md_start) mdFree = cyc + 1 + (d_md_is_div ? DIV_C : MULT_C);
    end
    cyc++;
  endfunction

  task automatic drive(int rs, int rt, int tRs, int tRt, int tn, bit wr, int dst,
                       bit ms = 0, bit dv = 0, bit acc = 0);
    d_rs_addr   = 5'(rs);
    d_rt_addr   = 5'(rt);
    d_tuse_rs   = 3'(tRs);
    d_tuse_rt   = 3'(tRt);
    d_tnew      = 3'(tn);
    d_reg_write = wr;
    d_dst_addr  = 5'(dst);
    d_md_start  = ms;
    d_md_is_div = dv;
    d_md_access = acc;
  endtask

  task automatic nop();
    drive(0, 0, 7, 7, 0, 0, 0);
  endtask

  // Inputs are applied just after a rising edge; outputs compared 1ns later.
  task automatic cycleCheck();
    #1;
    modelEval();
    lastStall = int'(stall);
    lastBusy  = int'(md_busy);
    chk("stall",    32'(stall),    eStall);
    chk("fwd_d_rs", 32'(fwd_d_rs), eFdRs);
    chk("fwd_d_rt", 32'(fwd_d_rt), eFdRt);
    chk("fwd_e_rs", 32'(fwd_e_rs), eFeRs);
    chk("fwd_e_rt", 32'(fwd_e_rt), eFeRt);
    chk("md_busy",  32'(md_busy),  eBusy);
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  function automatic int pickTuse();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 7 : r;
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    nop();
    modelClear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_stall",   32'(stall),   0);
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_fwd",     32'({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}), 0);

    // lw $1 ; addu $2,$1,$1
    drive(0, 0, 7, 7, 2, 1, 1);  cycleCheck();
    drive(1, 1, 1, 1, 1, 1, 2);  cycleCheck();
    chk("lw_use_stall", 32'(lastStall), 1);
    cycleCheck();
    chk("lw_use_release", 32'(lastStall), 0);
    nop(); cycleCheck(); cycleCheck();

    // addu $3 ; beq $3,$0
    drive(0, 0, 7, 7, 1, 1, 3);  cycleCheck();
    drive(3, 0, 0, 0, 0, 0, 0);  cycleCheck();
    chk("beq_stall", 32'(lastStall), 1);
    cycleCheck();
    chk("beq_release", 32'(lastStall), 0);
    nop(); cycleCheck(); cycleCheck();

    // ori $4 ; addu $4 ; consumer of $4 with tuse 1: E copy wins, no stall
    drive(0, 0, 7, 7, 1, 1, 4);  cycleCheck();
    drive(0, 0, 7, 7, 1, 1, 4);  cycleCheck();
    drive(4, 0, 1, 7, 1, 1, 5);  cycleCheck();
    chk("e_wins_stall", 32'(lastStall), 0);
    nop(); cycleCheck(); cycleCheck();

    // div ; mflo
    drive(0, 0, 7, 7, 0, 0, 0, 1, 1, 1);  cycleCheck();
    drive(0, 0, 7, 7, 1, 1, 6, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycleCheck();
      if (lastStall == 0) break;
      n++;
    end
    chk("div_mflo_stall_cycles", 32'(n), DIV_C);
    nop(); cycleCheck();

    // mult ; mult
    drive(0, 0, 7, 7, 0, 0, 0, 1, 0, 1);  cycleCheck();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycleCheck();
      if (lastStall == 0) break;
      n++;
    end
    chk("mult_mult_stall_cycles", 32'(n), MULT_C);
    nop();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycleCheck();
      if (lastBusy == 0) break;
      n++;
    end
    chk("mult_reload_busy_cycles", 32'(n), MULT_C);

    // reset in the middle of a division
    drive(0, 0, 7, 7, 0, 0, 0, 1, 1, 1);  cycleCheck();
    drive(0, 0, 7, 7, 1, 1, 6, 0, 0, 1);  cycleCheck(); cycleCheck(); cycleCheck();
    reset = 1'b1; nop(); cycleCheck();
    reset = 1'b0;
    drive(0, 0, 7, 7, 1, 1, 6, 0, 0, 1);  cycleCheck();
    chk("reset_mid_div_busy",  32'(lastBusy),  0);
    chk("reset_mid_div_stall", 32'(lastStall), 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      bit ms, acc;
      ms  = ($urandom_range(0, 7) == 0);
      acc = ms || ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), pickTuse(), pickTuse(),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            ms, 1'($urandom_range(0, 1)), acc);
      reset = ($urandom_range(0, 63) == 0);
      cycleCheck();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
